// File: rtl/hazard_unit_p.sv
// Second-generation hazard unit for the 5-stage pipeline: load-use / full interlock,
// branch shadow, multi-cycle MUL occupancy of EX, and saturating stall/flush statistics.
module hazard_unit_p #(
  parameter int OPW       = 4,
  parameter int REGW      = 5,
  parameter int BR_SHADOW = 2,
  parameter int MUL_LAT   = 3,
  parameter int FWD_EN    = 1,
  parameter int R0_ZERO   = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      ir_id_i,
  input  logic [31:0]      ir_ex_i,
  input  logic [31:0]      ir_mem_i,
  input  logic [31:0]      ir_wb_i,
  output logic             stall_pc_o,
  output logic             stall_ifid_o,
  output logic             bubble_o,
  output logic             hold_ex_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [OPW-1:0] OP_LW    = OPW'(0);
  localparam logic [OPW-1:0] OP_SW    = OPW'(1);
  localparam logic [OPW-1:0] OP_LI    = OPW'(2);
  localparam logic [OPW-1:0] OP_ADDU  = OPW'(3);
  localparam logic [OPW-1:0] OP_ADDIU = OPW'(4);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(5);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(6);
  localparam logic [OPW-1:0] OP_BGE   = OPW'(7);
  localparam logic [OPW-1:0] OP_J     = OPW'(8);
  localparam logic [OPW-1:0] OP_MULI  = OPW'(9);

  localparam logic [2:0] SH_LOAD = 3'(BR_SHADOW - 1);
  localparam logic [3:0] MUL_LIM = 4'(MUL_LAT - 1);

  logic [2:0]       shadow_cnt;
  logic [2:0]       mul_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic mul_busy, br_ex, data_haz;
  logic row_mul, row_sh, row_dh;
  logic unused_ok;

  function automatic logic [OPW-1:0] op_of(input logic [31:0] ir);
    return ir[31 -: OPW];
  endfunction

  function automatic logic [REGW-1:0] rd_of(input logic [31:0] ir);
    return ir[27 -: REGW];
  endfunction

  function automatic logic [REGW-1:0] rs_of(input logic [31:0] ir);
    return ir[22 -: REGW];
  endfunction

  function automatic logic [REGW-1:0] rt_of(input logic [31:0] ir);
    return ir[17 -: REGW];
  endfunction

  function automatic logic is_writer(input logic [OPW-1:0] op);
    return (op == OP_LW) || (op == OP_LI) || (op == OP_ADDU) || (op == OP_ADDIU) ||
           (op == OP_SLL) || (op == OP_MUL) || (op == OP_MULI);
  endfunction

  // True when the ID instruction reads the register written by wr_ir.
  function automatic logic dep_on(input logic [31:0] id_ir, input logic [31:0] wr_ir);
    logic [REGW-1:0] dst;
    logic use_rd, use_rs, use_rt, hit;
    dst    = rd_of(wr_ir);
    use_rd = 1'b0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (op_of(id_ir))
      OP_LW, OP_ADDIU, OP_SLL, OP_MULI: use_rs = 1'b1;
      OP_SW, OP_BGE: begin
        use_rd = 1'b1;
        use_rs = 1'b1;
      end
      OP_ADDU, OP_MUL: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: ;
    endcase
    hit = (use_rd && (rd_of(id_ir) == dst)) ||
          (use_rs && (rs_of(id_ir) == dst)) ||
          (use_rt && (rt_of(id_ir) == dst));
    if (!is_writer(op_of(wr_ir))) hit = 1'b0;
    if ((R0_ZERO != 0) && (dst == '0)) hit = 1'b0;
    return hit;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The MEM/WB word never creates a hazard; it is folded here only to keep it observed.
  assign unused_ok = ^{ir_wb_i, ir_id_i, ir_ex_i, ir_mem_i};

  always_comb begin
    mul_busy = ((op_of(ir_ex_i) == OP_MUL) || (op_of(ir_ex_i) == OP_MULI)) &&
               ({1'b0, mul_cnt} < MUL_LIM);
    br_ex    = (op_of(ir_ex_i) == OP_BGE) || (op_of(ir_ex_i) == OP_J);
    if (FWD_EN != 0) begin
      data_haz = (op_of(ir_ex_i) == OP_LW) && dep_on(ir_id_i, ir_ex_i);
    end else begin
      data_haz = dep_on(ir_id_i, ir_ex_i) || dep_on(ir_id_i, ir_mem_i);
    end
    row_mul = mul_busy;
    row_sh  = !mul_busy && ((shadow_cnt != 3'd0) || br_ex);
    row_dh  = !mul_busy && !row_sh && data_haz;
  end

  // Outputs are forced low for as long as reset is held, regardless of the ir inputs.
  always_comb begin
    stall_pc_o   = rst_ni && (row_mul || row_sh || row_dh);
    stall_ifid_o = rst_ni && (row_mul || row_dh);
    bubble_o     = rst_ni && (row_sh || row_dh);
    hold_ex_o    = rst_ni && row_mul;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_cnt <= 3'd0;
      mul_cnt    <= 3'd0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      mul_cnt <= mul_busy ? mul_cnt + 3'd1 : 3'd0;
      // Trigger only from an idle shadow; a running shadow just counts down.
      if (row_sh) shadow_cnt <= (shadow_cnt == 3'd0) ? SH_LOAD : shadow_cnt - 3'd1;
      if (row_mul || row_dh) stall_cnt <= sat_inc(stall_cnt);
      if (row_sh) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_hazard_unit_p.sv
// Bench for hazard_unit_p: three parameterisations share the ir inputs; expected output
// patterns are queued as stimulus is applied and compared when sampled at the falling edge.
module tb_hazard_unit_p;

  localparam logic [3:0] NO = 4'b0000;  // {stall_pc, stall_ifid, bubble, hold_ex}
  localparam logic [3:0] DH = 4'b1110;
  localparam logic [3:0] SH = 4'b1010;
  localparam logic [3:0] MH = 4'b1101;

  localparam logic [31:0] NOP_I       = {4'hF, 28'h0};
  localparam logic [31:0] LW_R3       = {4'd0, 5'd3, 5'd1, 5'd0, 13'd0};
  localparam logic [31:0] LW_R7       = {4'd0, 5'd7, 5'd1, 5'd0, 13'd0};
  localparam logic [31:0] ADDU_R4R3R5 = {4'd3, 5'd4, 5'd3, 5'd5, 13'd0};
  localparam logic [31:0] ADDU_R1R2R2 = {4'd3, 5'd1, 5'd2, 5'd2, 13'd0};
  localparam logic [31:0] ADDIU_R3    = {4'd4, 5'd3, 5'd1, 5'd0, 13'd0};
  localparam logic [31:0] ADDIU_R7    = {4'd4, 5'd7, 5'd1, 5'd0, 13'd0};
  localparam logic [31:0] ADDIU_R0    = {4'd4, 5'd0, 5'd1, 5'd0, 13'd0};
  localparam logic [31:0] SW_R7R2     = {4'd1, 5'd7, 5'd2, 5'd0, 13'd0};
  localparam logic [31:0] SW_R0R2     = {4'd1, 5'd0, 5'd2, 5'd0, 13'd0};
  localparam logic [31:0] SW_R1R2_T7  = {4'd1, 5'd1, 5'd2, 5'd7, 13'd0};
  localparam logic [31:0] BGE_I       = {4'd7, 5'd1, 5'd2, 5'd0, 13'd0};
  localparam logic [31:0] J_I         = {4'd8, 28'h0};
  localparam logic [31:0] MUL_R2      = {4'd6, 5'd2, 5'd1, 5'd1, 13'd0};

  typedef struct {
    string       tag;
    logic [11:0] outs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] ir_id, ir_ex, ir_mem, ir_wb;
  logic        a_spc, a_sif, a_bub, a_hex;
  logic        b_spc, b_sif, b_bub, b_hex;
  logic        c_spc, c_sif, c_bub, c_hex;
  logic [15:0] a_scnt, a_fcnt, c_scnt, c_fcnt;
  logic [3:0]  b_scnt, b_fcnt;
  logic [11:0] obs;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hazard_unit_p #(.BR_SHADOW(2), .MUL_LAT(3), .FWD_EN(1), .R0_ZERO(1), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_ni(rst_ni), .ir_id_i(ir_id), .ir_ex_i(ir_ex), .ir_mem_i(ir_mem),
    .ir_wb_i(ir_wb), .stall_pc_o(a_spc), .stall_ifid_o(a_sif), .bubble_o(a_bub),
    .hold_ex_o(a_hex), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt));

  hazard_unit_p #(.BR_SHADOW(4), .MUL_LAT(1), .FWD_EN(0), .R0_ZERO(1), .CNT_W(4)) u_b (
    .clk_i(clk), .rst_ni(rst_ni), .ir_id_i(ir_id), .ir_ex_i(ir_ex), .ir_mem_i(ir_mem),
    .ir_wb_i(ir_wb), .stall_pc_o(b_spc), .stall_ifid_o(b_sif), .bubble_o(b_bub),
    .hold_ex_o(b_hex), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt));

  hazard_unit_p #(.BR_SHADOW(2), .MUL_LAT(3), .FWD_EN(0), .R0_ZERO(1), .CNT_W(16)) u_c (
    .clk_i(clk), .rst_ni(rst_ni), .ir_id_i(ir_id), .ir_ex_i(ir_ex), .ir_mem_i(ir_mem),
    .ir_wb_i(ir_wb), .stall_pc_o(c_spc), .stall_ifid_o(c_sif), .bubble_o(c_bub),
    .hold_ex_o(c_hex), .stall_cnt_o(c_scnt), .flush_cnt_o(c_fcnt));

  assign obs = {a_spc, a_sif, a_bub, a_hex, b_spc, b_sif, b_bub, b_hex,
                c_spc, c_sif, c_bub, c_hex};

  task automatic do_reset();
    ir_id = NOP_I; ir_ex = NOP_I; ir_mem = NOP_I; ir_wb = NOP_I;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] ex_v [3] = '{LW_R3, NOP_I, LW_R3};
    logic        rs_v [3] = '{1'b0, 1'b1, 1'b1};
    logic [11:0] eo   [3] = '{{NO, NO, NO}, {NO, NO, NO}, {DH, DH, DH}};
    exp_t e;
    ir_id = ADDU_R4R3R5; ir_mem = NOP_I; ir_wb = LW_R3;
    for (int i = 0; i < 3; i++) begin
      ir_ex = ex_v[i]; rst_ni = rs_v[i];
      sb.push_back('{$sformatf("reset[%0d]", i), eo[i]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", e.tag, obs, e.outs);
      end
      checks++;
      if (i < 2 && {a_scnt, a_fcnt, b_scnt, b_fcnt, c_scnt, c_fcnt} !== 72'd0) begin
        errors++;
        $display("FAIL reset_cnt[%0d]: counters %h, expected 0", i,
                 {a_scnt, a_fcnt, b_scnt, b_fcnt, c_scnt, c_fcnt});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [31:0] ex_v  [4] = '{LW_R3, NOP_I, NOP_I, ADDIU_R3};
    logic [31:0] mem_v [4] = '{NOP_I, LW_R3, NOP_I, NOP_I};
    logic [11:0] eo    [4] = '{{DH, DH, DH}, {NO, DH, DH}, {NO, NO, NO}, {NO, DH, DH}};
    exp_t e;
    do_reset();
    ir_id = ADDU_R4R3R5;
    for (int i = 0; i < 4; i++) begin
      ir_ex = ex_v[i]; ir_mem = mem_v[i];
      sb.push_back('{$sformatf("load_use[%0d]", i), eo[i]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", e.tag, obs, e.outs);
      end
      if (i == 2) begin
        checks++;
        if (a_scnt !== 16'd1 || b_scnt !== 4'd2 || c_scnt !== 16'd2) begin
          errors++;
          $display("FAIL load_use_cnt: stall_cnt a=%0d b=%0d c=%0d, expected 1 2 2",
                   a_scnt, b_scnt, c_scnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_interlock();
    logic [31:0] id_v  [5] = '{SW_R7R2, SW_R0R2, SW_R1R2_T7, SW_R7R2, SW_R7R2};
    logic [31:0] ex_v  [5] = '{NOP_I, NOP_I, NOP_I, ADDIU_R7, LW_R7};
    logic [31:0] mem_v [5] = '{ADDIU_R7, ADDIU_R0, ADDIU_R7, NOP_I, NOP_I};
    logic [11:0] eo    [5] = '{{NO, DH, DH}, {NO, NO, NO}, {NO, NO, NO},
                               {NO, DH, DH}, {DH, DH, DH}};
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ir_id = id_v[i]; ir_ex = ex_v[i]; ir_mem = mem_v[i];
      sb.push_back('{$sformatf("interlock[%0d]", i), eo[i]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", e.tag, obs, e.outs);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [31:0] id_v  [5] = '{NOP_I, NOP_I, SW_R7R2, NOP_I, NOP_I};
    logic [31:0] ex_v  [5] = '{BGE_I, J_I, NOP_I, NOP_I, NOP_I};
    logic [31:0] mem_v [5] = '{NOP_I, NOP_I, ADDIU_R7, NOP_I, NOP_I};
    logic [11:0] eo    [5] = '{{SH, SH, SH}, {SH, SH, SH}, {NO, SH, DH},
                               {NO, SH, NO}, {NO, NO, NO}};
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ir_id = id_v[i]; ir_ex = ex_v[i]; ir_mem = mem_v[i];
      sb.push_back('{$sformatf("branch[%0d]", i), eo[i]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", e.tag, obs, e.outs);
      end
      if (i == 4) begin
        checks++;
        if (a_fcnt !== 16'd2 || b_fcnt !== 4'd4 || c_fcnt !== 16'd2 || c_scnt !== 16'd1) begin
          errors++;
          $display("FAIL branch_cnt: flush a=%0d b=%0d c=%0d stall_c=%0d, expected 2 4 2 1",
                   a_fcnt, b_fcnt, c_fcnt, c_scnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    logic [31:0] id_v  [8] = '{ADDU_R1R2R2, ADDU_R1R2R2, ADDU_R1R2R2, ADDU_R1R2R2,
                               NOP_I, NOP_I, NOP_I, NOP_I};
    logic [31:0] ex_v  [8] = '{MUL_R2, MUL_R2, MUL_R2, NOP_I, NOP_I, MUL_R2, MUL_R2, MUL_R2};
    logic [31:0] mem_v [8] = '{NOP_I, NOP_I, NOP_I, MUL_R2, NOP_I, NOP_I, NOP_I, NOP_I};
    logic [11:0] eo    [8] = '{{MH, DH, MH}, {MH, DH, MH}, {NO, DH, DH}, {NO, DH, DH},
                               {NO, NO, NO}, {MH, NO, MH}, {MH, NO, MH}, {NO, NO, NO}};
    exp_t e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ir_id = id_v[i]; ir_ex = ex_v[i]; ir_mem = mem_v[i];
      sb.push_back('{$sformatf("mul[%0d]", i), eo[i]});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", e.tag, obs, e.outs);
      end
      if (i == 4) begin
        checks++;
        if (a_scnt !== 16'd2 || b_scnt !== 4'd4 || c_scnt !== 16'd4) begin
          errors++;
          $display("FAIL mul_cnt: stall_cnt a=%0d b=%0d c=%0d, expected 2 4 4",
                   a_scnt, b_scnt, c_scnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_shadow();
    exp_t e;
    do_reset();
    ir_ex = BGE_I;
    sb.push_back('{"mid_shadow_trigger", {SH, SH, SH}});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e.outs) begin
      errors++;
      $display("FAIL %s: outputs %b, expected %b", e.tag, obs, e.outs);
    end
    @(posedge clk); #1;
    ir_ex = NOP_I;
    rst_ni = 1'b0;
    sb.push_back('{"mid_shadow_in_reset", {NO, NO, NO}});
    #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e.outs || a_fcnt !== 16'd0 || b_fcnt !== 4'd0) begin
      errors++;
      $display("FAIL %s: outputs %b flush a=%0d b=%0d, expected %b 0 0",
               e.tag, obs, a_fcnt, b_fcnt, e.outs);
    end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    sb.push_back('{"mid_shadow_released", {NO, NO, NO}});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e.outs) begin
      errors++;
      $display("FAIL %s: outputs %b, expected %b", e.tag, obs, e.outs);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    ir_id = ADDU_R4R3R5; ir_ex = LW_R3; ir_mem = NOP_I;
    for (int i = 0; i < 20; i++) begin
      sb.push_back('{$sformatf("sat[%0d]", i), {DH, DH, DH}});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.outs) begin
        errors++;
        $display("FAIL %s: outputs %b, expected %b", e.tag, obs, e.outs);
      end
      if (i == 16) begin
        checks++;
        if (b_scnt !== 4'd15 || a_scnt !== 16'd16) begin
          errors++;
          $display("FAIL sat_16: stall_cnt a=%0d b=%0d, expected 16 15", a_scnt, b_scnt);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (b_scnt !== 4'd15 || a_scnt !== 16'd20 || c_scnt !== 16'd20) begin
      errors++;
      $display("FAIL sat_end: stall_cnt a=%0d b=%0d c=%0d, expected 20 15 20",
               a_scnt, b_scnt, c_scnt);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    ir_id = NOP_I; ir_ex = NOP_I; ir_mem = NOP_I; ir_wb = NOP_I;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_interlock();
    test_branch();
    test_mul();
    test_reset_mid_shadow();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
